// File: rtl/calc_unit.sv
// Execute stage sequenced by the CPU state bus: latches opcode/operands, runs ALU or iterative MUL/DIV/MOD.
// Build option CALC_FAST_MUL_EN: single-cycle combinational MUL instead of the shift-add loop.
package calc_unit_pkg;
  typedef enum logic [3:0] {
    SIDLE, SREAD, SLOAD1, SLOAD2, SCALC, SWRITE, SNXTLINE, SERR, SFINISH
  } SequencerState;
  typedef enum logic [2:0] {CIDLE, CBUSY, CDONE, CHALT, CFAULT} calc_state_t;
endpackage

module calc_unit
  import calc_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  SequencerState        q,
  input  logic [OPW-1:0]       instr,
  input  logic [WIDTH-1:0]     opnd,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 carry,
  output logic                 ovf,
  output logic                 nxt_line,
  output logic                 finish,
  output logic                 err,
  output calc_state_t          dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_MOD  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

  calc_state_t        state;
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, rem_q, quo_q;

  // Handshake: nxt_line/finish are only meaningful while q==SCALC and are
  // gated by it; the sequencer treats them as its advance strobes. err is a
  // level that persists regardless of q.
  assign nxt_line  = (state == CDONE) && (q == SCALC);
  assign finish    = (state == CHALT) && (q == SCALC);
  assign err       = (state == CFAULT);
  assign dbg_state = state;

  logic legal, div_op, multi;
  assign legal  = (op_q <= OP_MOD) || (op_q == OP_HALT);
  assign div_op = (op_q == OP_DIV) || (op_q == OP_MOD);
`ifdef CALC_FAST_MUL_EN
  assign multi  = div_op;
`else
  assign multi  = div_op || (op_q == OP_MUL);
`endif

  // Single-cycle ops
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o, shift_big;
`ifdef CALC_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    shift_big = (32'(b_q) >= WIDTH);
    alu_res   = result;
    alu_c     = 1'b0;
    alu_o     = 1'b0;
`ifdef CALC_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: alu_res = shift_big ? '0 : (a_q << b_q);
      OP_SHR: alu_res = shift_big ? '0 : (a_q >> b_q);
`ifdef CALC_FAST_MUL_EN
      OP_MUL: begin
        alu_res = fast_prod[WIDTH-1:0];
        alu_o   = |fast_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  // One shift-add / restoring-division iteration. The first iteration runs on
  // the CIDLE->CBUSY edge straight from the operands, so WIDTH iterations end
  // at the edge closing k=WIDTH-1.
  logic [2*WIDTH-1:0] in_acc, in_mcand, st_acc, st_mcand;
  logic [WIDTH-1:0]   in_mplier, st_mplier, in_rem, in_quo, st_rem, st_quo, it_res;
  logic [WIDTH:0]     sh_rem, rem_diff;
  logic               it_o;
  always_comb begin
    if (state == CIDLE) begin
      in_acc    = '0;
      in_mcand  = {{WIDTH{1'b0}}, a_q};
      in_mplier = b_q;
      in_rem    = '0;
      in_quo    = a_q;
    end else begin
      in_acc    = acc_q;
      in_mcand  = mcand_q;
      in_mplier = mplier_q;
      in_rem    = rem_q;
      in_quo    = quo_q;
    end
    st_acc    = in_mplier[0] ? (in_acc + in_mcand) : in_acc;
    st_mcand  = in_mcand << 1;
    st_mplier = in_mplier >> 1;
    sh_rem    = {in_rem, in_quo[WIDTH-1]};
    rem_diff  = sh_rem - {1'b0, b_q};
    st_quo    = {in_quo[WIDTH-2:0], ~rem_diff[WIDTH]};
    st_rem    = rem_diff[WIDTH] ? sh_rem[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    it_res    = (op_q == OP_MUL) ? st_acc[WIDTH-1:0] :
                (op_q == OP_DIV) ? st_quo : st_rem;
    it_o      = (op_q == OP_MUL) && (|st_acc[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= CIDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      if (q == SREAD)  op_q <= instr;
      if (q == SLOAD1) a_q  <= opnd;
      if (q == SLOAD2) b_q  <= opnd;
      case (state)
        CIDLE: if (q == SCALC) begin
          if (!legal || (div_op && (b_q == '0))) begin
            state <= CFAULT;
          end else if (op_q == OP_HALT) begin
            state <= CHALT;
          end else if (multi) begin
            state    <= CBUSY;
            cnt      <= CW'(WIDTH - 1);
            acc_q    <= st_acc;
            mcand_q  <= st_mcand;
            mplier_q <= st_mplier;
            rem_q    <= st_rem;
            quo_q    <= st_quo;
          end else begin
            state <= CDONE;
            if (op_q != OP_NOP) begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              carry  <= alu_c;
              ovf    <= alu_o;
            end
          end
        end
        CBUSY: begin
          if (q != SCALC) begin
            state <= CIDLE;
          end else begin
            cnt      <= cnt - 1'b1;
            acc_q    <= st_acc;
            mcand_q  <= st_mcand;
            mplier_q <= st_mplier;
            rem_q    <= st_rem;
            quo_q    <= st_quo;
            if (cnt == CW'(1)) begin
              state  <= CDONE;
              result <= it_res;
              zero   <= (it_res == '0);
              carry  <= 1'b0;
              ovf    <= it_o;
            end
          end
        end
        CDONE:   if (q != SCALC) state <= CIDLE;
        CHALT:   state <= CHALT;
        CFAULT:  state <= CFAULT;
        default: state <= CIDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_unit.sv
// Bench for calc_unit: directed vector table, randomized lines against an arithmetic model,
// and hand sequences for HALT, faults and mid-operation reset.
module tb_calc_unit;
  import calc_unit_pkg::*;
  localparam int W = 8;
  localparam int M = 1 << W;
`ifdef CALC_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  SequencerState q = SIDLE;
  logic [3:0] instr = '0;
  logic [W-1:0] opnd = '0;
  logic [W-1:0] result;
  logic zero, carry, ovf, nxt_line, finish, err;
  calc_state_t dbg_state;

  calc_unit #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rstn(rstn), .q(q), .instr(instr), .opnd(opnd),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf),
    .nxt_line(nxt_line), .finish(finish), .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // Reference state: last committed result and flags
  int m_res, m_z, m_c, m_o;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q = SIDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_res = 0; m_z = 0; m_c = 0; m_o = 0;
  endtask

  task automatic step(input SequencerState s, input logic [3:0] i, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    q = s;
    instr = i;
    opnd = d;
  endtask

  // Drives one instruction up to the first cycle showing nxt_line/finish/err.
  task automatic run_line(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
    step(SREAD, op, W'($urandom));
    step(SLOAD1, 4'($urandom), a);
    step(SLOAD2, 4'($urandom), b);
    step(SCALC, 4'($urandom), W'($urandom));
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (nxt_line || finish || err) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic close_line(input logic [W-1:0] exp_res);
    step(SWRITE, 4'($urandom), W'($urandom));
    @(negedge clk);
    chk("nxt_line_in_swrite", 32'(nxt_line), 32'(0));
    chk("result_in_swrite", 32'(result), 32'(exp_res));
    step(SNXTLINE, 4'($urandom), W'($urandom));
    step(SIDLE, 4'($urandom), W'($urandom));
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Arithmetic model working on plain integers
  task automatic model(input int op, input int a, input int b);
    int r, s;
    case (op)
      1: begin r = a + b; s = sgn(a) + sgn(b); m_c = int'(r >= M); m_o = int'(s >= M/2 || s < -M/2); r = r % M; end
      2: begin r = a - b; s = sgn(a) - sgn(b); m_c = int'(a < b); m_o = int'(s >= M/2 || s < -M/2); r = (r + M) % M; end
      3: begin r = a & b; m_c = 0; m_o = 0; end
      4: begin r = a | b; m_c = 0; m_o = 0; end
      5: begin r = a ^ b; m_c = 0; m_o = 0; end
      6: begin r = (b >= W) ? 0 : (a * (1 << b)) % M; m_c = 0; m_o = 0; end
      7: begin r = (b >= W) ? 0 : a / (1 << b); m_c = 0; m_o = 0; end
      8: begin r = (a * b) % M; m_c = 0; m_o = int'(a * b >= M); end
      9: begin r = a / b; m_c = 0; m_o = 0; end
      10: begin r = a % b; m_c = 0; m_o = 0; end
      default: return;
    endcase
    m_res = r;
    m_z = int'(r == 0);
  endtask

  function automatic int exp_lat(input int op);
    if (op == 8) return MUL_LAT;
    if (op == 9 || op == 10) return W;
    return 1;
  endfunction

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, o;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int lat, bad;
    logic [W-1:0] got_exp;
    tbl.push_back('{4'h1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'h2, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'h2, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h8, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h8, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h9, 8'd100, 8'd7, 8'd14, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'hA, 8'd100, 8'd7, 8'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h0, 8'h33, 8'h44, 8'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h4, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h6, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h6, 8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'h7, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h7, 8'hFF, 8'h09, 8'h00, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'h1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{4'h2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1});

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_zero", 32'(zero), 32'(0));
    chk("rst_carry", 32'(carry), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_nxt_line", 32'(nxt_line), 32'(0));
    chk("rst_finish", 32'(finish), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(CIDLE));

    // Directed vectors
    foreach (tbl[i]) begin
      run_line(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(exp_lat(int'(tbl[i].op))));
      chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].res));
      chk($sformatf("tbl%0d_flags", i), 32'({zero, carry, ovf}), 32'({tbl[i].z, tbl[i].c, tbl[i].o}));
      close_line(tbl[i].res);
    end
    m_res = int'(tbl[tbl.size()-1].res);
    m_z = int'(tbl[tbl.size()-1].z);
    m_c = int'(tbl[tbl.size()-1].c);
    m_o = int'(tbl[tbl.size()-1].o);

    // Randomized lines against the model
    for (int n = 0; n < 40; n++) begin
      int op, a, b;
      op = $urandom_range(0, 10);
      a = $urandom_range(0, M - 1);
      b = (op == 6 || op == 7) ? $urandom_range(0, W + 1) : $urandom_range(0, M - 1);
      if ((op == 9 || op == 10) && b == 0) b = $urandom_range(1, M - 1);
      model(op, a, b);
      exp_q.push_back(W'(m_res));
      run_line(4'(op), W'(a), W'(b), lat);
      got_exp = exp_q.pop_front();
      chk($sformatf("rnd%0d_op%0d_lat", n, op), 32'(lat), 32'(exp_lat(op)));
      chk($sformatf("rnd%0d_op%0d_result", n, op), 32'(result), 32'(got_exp));
      chk($sformatf("rnd%0d_op%0d_flags", n, op), 32'({zero, carry, ovf}), 32'({m_z[0], m_c[0], m_o[0]}));
      close_line(got_exp);
    end

    // HALT: finish at k=1, result and flags held
    run_line(4'hF, 8'h12, 8'h34, lat);
    chk("halt_lat", 32'(lat), 32'(1));
    chk("halt_finish", 32'(finish), 32'(1));
    chk("halt_nxt_line", 32'(nxt_line), 32'(0));
    chk("halt_result", 32'(result), 32'(m_res));
    chk("halt_flags", 32'({zero, carry, ovf}), 32'({m_z[0], m_c[0], m_o[0]}));
    step(SFINISH, 4'h0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_parked_state", 32'(dbg_state), 32'(CHALT));
    chk("halt_finish_gated", 32'(finish), 32'(0));
    do_reset();

    // Faults: divide by zero and illegal opcode
    for (int f = 0; f < 2; f++) begin
      logic [3:0] fop;
      fop = (f == 0) ? 4'h9 : 4'hB;
      run_line(fop, 8'd100, 8'd0, lat);
      chk($sformatf("fault%0d_err_lat", f), 32'(lat), 32'(1));
      chk($sformatf("fault%0d_err", f), 32'(err), 32'(1));
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        q = (c < 10) ? SCALC : SERR;
        @(negedge clk);
        if (!err || nxt_line) bad++;
      end
      chk($sformatf("fault%0d_sticky_cycles_bad", f), 32'(bad), 32'(0));
      rstn = 1'b0;
      #2;
      chk($sformatf("fault%0d_err_cleared", f), 32'(err), 32'(0));
      do_reset();
    end

    // Reset dropped at k=3 of a MUL after a nonzero result
    run_line(4'h1, 8'h7F, 8'h01, lat);
    close_line(8'h80);
    step(SREAD, 4'h8, 8'h00);
    step(SLOAD1, 4'h0, 8'd13);
    step(SLOAD2, 4'h0, 8'd11);
    step(SCALC, 4'h0, 8'h00);
    repeat (3) step(SCALC, 4'h0, 8'h00);
    rstn = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'(0));
    chk("midrst_flags", 32'({zero, carry, ovf}), 32'(0));
    chk("midrst_strobes", 32'({nxt_line, finish, err}), 32'(0));
    q = SIDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state_after_release", 32'(dbg_state), 32'(CIDLE));
    m_res = 0; m_z = 0; m_c = 0; m_o = 0;

    // Line after recovery must run normally
    run_line(4'h9, 8'd100, 8'd7, lat);
    chk("recover_lat", 32'(lat), 32'(W));
    chk("recover_result", 32'(result), 32'(14));
    close_line(8'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
